// File: rtl/spi_cfg_arbiter.sv
// SPI configuration arbiter: replays a power-up write table through the SPI master,
// then serves two requesters round-robin, one transaction at a time, with a timeout guard.
module spi_cfg_arbiter #(
    parameter int unsigned NUM_INIT       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_we,
    input  logic [13:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_done,
    output logic [7:0]  o_rdata,
    output logic [7:0]  o_initIndex,
    input  logic [6:0]  i_initAddress,
    input  logic [7:0]  i_initData,
    output logic        o_initDone,
    output logic        o_timeout,
    output logic        o_txBegin,
    output logic [6:0]  o_txAddress,
    output logic [7:0]  o_txData,
    input  logic        i_txDone,
    output logic        o_rxBegin,
    output logic [6:0]  o_rxAddress,
    input  logic [7:0]  i_rxData,
    input  logic        i_rxDone
);
    localparam logic [7:0]  LAST_INDEX = 8'(NUM_INIT - 1);
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        ISSUE,
        WAIT,
        COMPLETE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic        initDone_q, initDone_d;
    logic        timeout_q, timeout_d;
    logic        txBegin_q, txBegin_d;
    logic        rxBegin_q, rxBegin_d;
    logic [6:0]  txAddr_q, txAddr_d;
    logic [7:0]  txData_q, txData_d;
    logic [6:0]  rxAddr_q, rxAddr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        expired;
    logic        win;
    logic        matched;

    assign expired = (cnt_q == LAST_COUNT);
    assign win     = (i_req == 2'b11) ? ~last_q : i_req[1];
    assign matched = we_q ? i_txDone : i_rxDone;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= INIT_ISSUE;
            index_q    <= '0;
            initDone_q <= 1'b0;
            timeout_q  <= 1'b0;
            txBegin_q  <= 1'b0;
            rxBegin_q  <= 1'b0;
            txAddr_q   <= '0;
            txData_q   <= '0;
            rxAddr_q   <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            initDone_q <= initDone_d;
            timeout_q  <= timeout_d;
            txBegin_q  <= txBegin_d;
            rxBegin_q  <= rxBegin_d;
            txAddr_q   <= txAddr_d;
            txData_q   <= txData_d;
            rxAddr_q   <= rxAddr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Pulse outputs are registered, so each pulse is visible during the state it leads into;
    // this keeps every output at zero while reset is asserted.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        initDone_d = initDone_q;
        timeout_d  = timeout_q;
        txBegin_d  = 1'b0;
        rxBegin_d  = 1'b0;
        txAddr_d   = txAddr_q;
        txData_d   = txData_q;
        rxAddr_d   = rxAddr_q;
        gnt_d      = '0;
        done_d     = '0;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            INIT_ISSUE: begin
                txBegin_d = 1'b1;
                txAddr_d  = i_initAddress;
                txData_d  = i_initData;
                cnt_d     = '0;
                state_d   = INIT_WAIT;
            end
            INIT_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (i_txDone || expired) begin
                    if (!i_txDone) begin
                        timeout_d = 1'b1;
                    end
                    if (index_q == LAST_INDEX) begin
                        initDone_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = INIT_ISSUE;
                    end
                end
            end
            IDLE: begin
                if (|i_req) begin
                    gnt_d[win] = 1'b1;
                    last_d     = win;
                    sel_d      = win;
                    we_d       = i_we[win];
                    addr_d     = win ? i_addr[13:7] : i_addr[6:0];
                    wdata_d    = win ? i_wdata[15:8] : i_wdata[7:0];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    txBegin_d = 1'b1;
                    txAddr_d  = addr_q;
                    txData_d  = wdata_q;
                end else begin
                    rxBegin_d = 1'b1;
                    rxAddr_d  = addr_q;
                end
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (matched || expired) begin
                    if (!matched) begin
                        timeout_d = 1'b1;
                    end
                    if (!we_q) begin
                        rdata_d = matched ? i_rxData : 8'hFF;
                    end
                    done_d[sel_q] = 1'b1;
                    state_d       = COMPLETE;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_gnt       = gnt_q;
    assign o_done      = done_q;
    assign o_rdata     = rdata_q;
    assign o_initIndex = index_q;
    assign o_initDone  = initDone_q;
    assign o_timeout   = timeout_q;
    assign o_txBegin   = txBegin_q;
    assign o_txAddress = txAddr_q;
    assign o_txData    = txData_q;
    assign o_rxBegin   = rxBegin_q;
    assign o_rxAddress = rxAddr_q;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Randomized bench for spi_cfg_arbiter: requester and SPI master models drive the DUT,
// and a transaction-level reference checks every output on every cycle.
module tb_spi_cfg_arbiter;
    localparam int NI = 3;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  i_req, i_we, o_gnt, o_done;
    logic [13:0] i_addr;
    logic [15:0] i_wdata;
    logic [7:0]  o_rdata, o_initIndex, i_initData, o_txData, i_rxData;
    logic [6:0]  i_initAddress, o_txAddress, o_rxAddress;
    logic        o_initDone, o_timeout, o_txBegin, o_rxBegin, i_txDone, i_rxDone;

    spi_cfg_arbiter #(.NUM_INIT(NI), .TIMEOUT_CYCLES(TO)) dut (
        .i_clock(clk), .i_resetn(rstn), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata),
        .o_initIndex(o_initIndex), .i_initAddress(i_initAddress), .i_initData(i_initData),
        .o_initDone(o_initDone), .o_timeout(o_timeout), .o_txBegin(o_txBegin),
        .o_txAddress(o_txAddress), .o_txData(o_txData), .i_txDone(i_txDone),
        .o_rxBegin(o_rxBegin), .o_rxAddress(o_rxAddress), .i_rxData(i_rxData),
        .i_rxDone(i_rxDone)
    );

    always #5 clk = ~clk;

    logic [6:0] tblA [NI] = '{7'h10, 7'h11, 7'h12};
    logic [7:0] tblD [NI] = '{8'hA1, 8'hB2, 8'hC3};

    always_comb begin
        i_initAddress = 7'h00;
        i_initData    = 8'h00;
        for (int k = 0; k < NI; k++) begin
            if (int'(o_initIndex) == k) begin
                i_initAddress = tblA[k];
                i_initData    = tblD[k];
            end
        end
    end

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state
    bit expInitDone, expTimeout, outValid, outBegun, outWe, doneInit, doneTO;
    int initCount, lastG, outReq, doneAt, idleWait;
    logic [6:0] outAddr;
    logic [7:0] outData, expRdata;
    // SPI master model
    bit mBusy, mWrite, mNever;
    int mDoneCyc, mBegin;
    logic [6:0] mAddr;
    logic [7:0] mData, mRx;
    // Requester model
    bit reqV [2];
    bit reqWe [2];
    logic [6:0] reqA [2];
    logic [7:0] reqD [2];
    bit autoReq, holdBoth, randNever, forceNever;
    int forceRx;
    // Logs for the directed literal checks
    int gntLog[$];
    logic [6:0] initLogA[$];
    logic [7:0] initLogD[$];
    int lastDoneCyc, lastDoneBeginCyc;
    logic [7:0] lastRdata;
    logic [1:0] lastDone;
    logic [6:0] lastRxAddr;
    logic lastTimeout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        i_req   = {reqV[1], reqV[0]};
        i_we    = {reqWe[1], reqWe[0]};
        i_addr  = {reqA[1], reqA[0]};
        i_wdata = {reqD[1], reqD[0]};
    endtask

    task automatic newReq(input int n);
        reqV[n]  = 1'b1;
        reqWe[n] = 1'($urandom);
        reqA[n]  = 7'($urandom);
        reqD[n]  = 8'($urandom);
    endtask

    task automatic modelReset();
        expInitDone = 0; expTimeout = 0; outValid = 0; outBegun = 0; doneInit = 0; doneTO = 0;
        initCount = 0; lastG = 1; doneAt = -1; idleWait = 0;
        mBusy = 0; mNever = 0; forceNever = 0; forceRx = -1;
        for (int n = 0; n < 2; n++) begin
            reqV[n] = 0; reqWe[n] = 0; reqA[n] = '0; reqD[n] = '0;
        end
        i_txDone = 1'b0; i_rxDone = 1'b0; i_rxData = '0;
        drive();
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_gnt"}, o_gnt, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rdata"}, o_rdata, 0);
        chk({tag, "_index"}, o_initIndex, 0);
        chk({tag, "_initDone"}, o_initDone, 0);
        chk({tag, "_timeout"}, o_timeout, 0);
        chk({tag, "_txBegin"}, o_txBegin, 0);
        chk({tag, "_rxBegin"}, o_rxBegin, 0);
        chk({tag, "_txAddr"}, o_txAddress, 0);
        chk({tag, "_txData"}, o_txData, 0);
        chk({tag, "_rxAddr"}, o_rxAddress, 0);
    endtask

    // One clock period: compare outputs, advance the models, drive the next inputs.
    task automatic cycle();
        logic [1:0] expDone;
        int w;
        @(negedge clk);
        cyc++;
        i_txDone = 1'b0;
        i_rxDone = 1'b0;
        i_rxData = 8'($urandom);
        expDone  = 2'b00;

        if (cyc == doneAt) begin
            if (doneTO) expTimeout = 1'b1;
            if (doneInit) begin
                initCount++;
                if (initCount == NI) expInitDone = 1'b1;
            end else begin
                expDone          = 2'(1 << outReq);
                outValid         = 1'b0;
                lastDone         = o_done;
                lastRdata        = o_rdata;
                lastTimeout      = o_timeout;
                lastDoneCyc      = cyc;
                lastDoneBeginCyc = mBegin;
                if (!outWe) chk("rdata", o_rdata, expRdata);
            end
            doneAt = -1;
        end
        chk("done", o_done, expDone);
        chk("timeout", o_timeout, expTimeout);
        chk("initDone", o_initDone, expInitDone);
        chk("initIndex", o_initIndex, (initCount < NI) ? initCount : NI - 1);
        chk("beginExcl", o_txBegin & o_rxBegin, 0);

        if (o_txBegin || o_rxBegin) begin
            chk("beginMasterIdle", mBusy, 0);
            if (!expInitDone) begin
                chk("initIsWrite", o_txBegin, 1);
                if (initCount < NI) begin
                    chk("initAddr", o_txAddress, tblA[initCount]);
                    chk("initData", o_txData, tblD[initCount]);
                end else begin
                    chk("initExtraBegin", initCount, NI - 1);
                end
                initLogA.push_back(o_txAddress);
                initLogD.push_back(o_txData);
                doneInit = 1;
            end else begin
                chk("beginExpected", outValid && !outBegun, 1);
                chk("beginDir", o_txBegin, outWe);
                if (o_txBegin) begin
                    chk("txAddr", o_txAddress, outAddr);
                    chk("txData", o_txData, outData);
                end else begin
                    chk("rxAddr", o_rxAddress, outAddr);
                    lastRxAddr = o_rxAddress;
                end
                outBegun = 1;
                doneInit = 0;
            end
            mBusy  = 1;
            mWrite = o_txBegin;
            mAddr  = o_txBegin ? o_txAddress : o_rxAddress;
            mData  = o_txData;
            mBegin = cyc;
            mRx    = (forceRx >= 0) ? 8'(forceRx) : 8'($urandom);
            mNever = !doneInit && (forceNever || (randNever && $urandom_range(0, 5) == 0));
            forceNever = 0;
            forceRx    = -1;
            if (mNever) begin
                mDoneCyc = cyc + TO;
                doneAt   = cyc + TO;
                doneTO   = 1;
                expRdata = 8'hFF;
            end else begin
                mDoneCyc = cyc + (doneInit ? 40 : int'($urandom_range(1, 30)));
                doneAt   = mDoneCyc + 1;
                doneTO   = 0;
                expRdata = mRx;
            end
        end else if (mBusy) begin
            if (mWrite) begin
                chk("txAddrHold", o_txAddress, mAddr);
                chk("txDataHold", o_txData, mData);
            end else begin
                chk("rxAddrHold", o_rxAddress, mAddr);
            end
        end

        if (o_gnt != 2'b00) begin
            if (reqV[0] && reqV[1]) w = 1 - lastG;
            else if (reqV[0]) w = 0;
            else if (reqV[1]) w = 1;
            else w = -1;
            chk("gntAllowed", expInitDone && !outValid, 1);
            chk("gntWinner", o_gnt, (w < 0) ? 0 : (1 << w));
            if (w >= 0) begin
                lastG    = w;
                outValid = 1;
                outBegun = 0;
                outReq   = w;
                outWe    = reqWe[w];
                outAddr  = reqA[w];
                outData  = reqD[w];
                reqV[w]  = 0;
                gntLog.push_back(w);
            end
            idleWait = 0;
        end else if (expInitDone && !outValid && (reqV[0] || reqV[1])) begin
            idleWait++;
            if (idleWait > 3) begin
                chk("gntLatency", idleWait, 3);
                idleWait = 0;
            end
        end

        if (mBusy && !mNever && cyc == mDoneCyc) begin
            if (mWrite) begin
                i_txDone = 1'b1;
            end else begin
                i_rxDone = 1'b1;
                i_rxData = mRx;
            end
            mBusy = 0;
        end else if (mBusy && mNever && cyc == mDoneCyc) begin
            mBusy = 0;
        end else if (mBusy && cyc != mBegin && $urandom_range(0, 7) == 0) begin
            if (mWrite) i_rxDone = 1'b1;
            else i_txDone = 1'b1;
        end

        for (int n = 0; n < 2; n++) begin
            if (!reqV[n] && (holdBoth || (autoReq && $urandom_range(0, 3) == 0))) newReq(n);
        end
        drive();
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && (outValid || reqV[0] || reqV[1] || mBusy); k++) cycle();
        chk("drain", {outValid, reqV[0], reqV[1], mBusy}, 0);
    endtask

    initial begin
        autoReq = 0; holdBoth = 0; randNever = 0;
        modelReset();
        rstn = 1'b0;
        #3;
        checkAllZero("reset0");
        repeat (2) cycle();
        holdBoth = 1;
        rstn = 1'b1;

        // Init sequence, then both requesters held busy: grants must alternate from 0.
        for (int k = 0; k < 2000 && gntLog.size() < 6; k++) cycle();
        chk("req041_grantCount", gntLog.size() >= 6, 1);
        chk("req040_writes", initLogA.size(), 3);
        if (initLogA.size() == 3) begin
            chk("req040_a0", initLogA[0], 7'h10);
            chk("req040_d0", initLogD[0], 8'hA1);
            chk("req040_a1", initLogA[1], 7'h11);
            chk("req040_d1", initLogD[1], 8'hB2);
            chk("req040_a2", initLogA[2], 7'h12);
            chk("req040_d2", initLogD[2], 8'hC3);
        end
        if (gntLog.size() >= 4) begin
            chk("req041_g0", gntLog[0], 0);
            chk("req041_g1", gntLog[1], 1);
            chk("req041_g2", gntLog[2], 0);
            chk("req041_g3", gntLog[3], 1);
        end
        holdBoth = 0;
        drain();

        // Requester 1 read of 0x2C returning 0x5E.
        reqWe[1] = 0; reqA[1] = 7'h2C; reqD[1] = 8'h00; reqV[1] = 1;
        forceRx = 8'h5E;
        drive();
        drain();
        chk("req042_done", lastDone, 2'b10);
        chk("req042_rdata", lastRdata, 8'h5E);
        chk("req042_rxAddr", lastRxAddr, 7'h2C);

        // Read that never completes: timeout after 50 cycles, then a normal write.
        reqWe[0] = 0; reqA[0] = 7'h33; reqD[0] = 8'h00; reqV[0] = 1;
        forceNever = 1;
        drive();
        drain();
        chk("req043_timeout", lastTimeout, 1);
        chk("req043_rdata", lastRdata, 8'hFF);
        chk("req043_latency", lastDoneCyc - lastDoneBeginCyc, 50);
        chk("req043_done", lastDone, 2'b01);
        reqWe[1] = 1; reqA[1] = 7'h05; reqD[1] = 8'h77; reqV[1] = 1;
        drive();
        drain();
        chk("req043_next", lastDone, 2'b10);

        // Random traffic with occasional unanswered transactions.
        autoReq = 1; randNever = 1;
        repeat (1500) cycle();
        autoReq = 0; randNever = 0;
        drain();

        // Reset in the middle of a WAIT.
        reqWe[0] = 0; reqA[0] = 7'h44; reqV[0] = 1;
        forceNever = 1;
        drive();
        for (int k = 0; k < 50 && !(mBusy && outBegun); k++) cycle();
        chk("req044_inWait", mBusy && outBegun, 1);
        repeat (5) cycle();
        #2 rstn = 1'b0;
        #1 checkAllZero("req044_reset");
        modelReset();
        initLogA.delete();
        initLogD.delete();
        gntLog.delete();
        repeat (3) cycle();
        holdBoth = 1;
        rstn = 1'b1;
        for (int k = 0; k < 1000 && gntLog.size() < 2; k++) cycle();
        holdBoth = 0;
        chk("req044_initRestart", initLogA.size(), 3);
        if (initLogA.size() > 0) chk("req044_firstInit", initLogA[0], 7'h10);
        if (gntLog.size() > 0) chk("req044_firstGnt", gntLog[0], 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cfg_arbiter.md
SPI_CFG_ARBITER -- requirements
Module: spi_cfg_arbiter

Interface
REQ-001 SHALL have parameter NUM_INIT, default 8: number of entries in the power-up write table (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095: maximum cycles from a begin pulse to the done pulse (1..65535).
REQ-003 SHALL have port i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  2  per-requester transaction request, level, bit n = requester n.
REQ-006 SHALL have port i_we  input  2  per-requester direction: 1 = write, 0 = read.
REQ-007 SHALL have port i_addr  input  14  per-requester 7-bit register address; requester n uses [7n+6:7n].
REQ-008 SHALL have port i_wdata  input  16  per-requester write data; requester n uses [8n+7:8n].
REQ-009 SHALL have port o_gnt  output  2  one-cycle pulse: request n accepted, inputs captured.
REQ-010 SHALL have port o_done  output  2  one-cycle pulse: transaction of requester n complete.
REQ-011 SHALL have port o_rdata  output  8  read result; valid in the o_done cycle of a read.
REQ-012 SHALL have port o_initIndex  output  8  index into the external init table.
REQ-013 SHALL have port i_initAddress  input  7  table register address at o_initIndex.
REQ-014 SHALL have port i_initData  input  8  table write data at o_initIndex.
REQ-015 SHALL have port o_initDone  output  1  high once every init entry is written; held until reset.
REQ-016 SHALL have port o_timeout  output  1  sticky error: a transaction exceeded TIMEOUT_CYCLES.
REQ-017 SHALL have port o_txBegin  output  1  one-cycle write-start pulse to the SPI master.
REQ-018 SHALL have port o_txAddress  output  7  write address to the SPI master.
REQ-019 SHALL have port o_txData  output  8  write data to the SPI master.
REQ-020 SHALL have port i_txDone  input  1  SPI master write-complete pulse.
REQ-021 SHALL have port o_rxBegin  output  1  one-cycle read-start pulse to the SPI master.
REQ-022 SHALL have port o_rxAddress  output  7  read address to the SPI master.
REQ-023 SHALL have port i_rxData  input  8  SPI master read data, valid with i_rxDone.
REQ-024 SHALL have port i_rxDone  input  1  SPI master read-complete pulse.

Function
REQ-025 SHALL implement states INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT, COMPLETE; reset enters INIT_ISSUE with o_initIndex=0.
REQ-026 INIT_ISSUE SHALL pulse o_txBegin with o_txAddress=i_initAddress, o_txData=i_initData, then enter INIT_WAIT.
REQ-027 INIT_WAIT on i_txDone or timeout: if o_initIndex==NUM_INIT-1, set o_initDone=1 and go IDLE; else increment o_initIndex and go INIT_ISSUE.
REQ-028 SHALL issue no o_gnt while o_initDone=0; pending requests wait, none are lost.
REQ-029 IDLE with any i_req bit set SHALL pulse o_gnt for exactly one winner, capture its we/addr/wdata, and enter ISSUE next cycle.
REQ-030 Arbitration SHALL be round-robin: the winner is the requester not granted last; first grant after reset goes to requester 0; a lone requester always wins.
REQ-031 ISSUE SHALL pulse o_txBegin (write) or o_rxBegin (read, o_rxAddress=captured address), never both, then enter WAIT.
REQ-032 WAIT SHALL accept only the done input matching the issued direction; the other done input is ignored.
REQ-033 WAIT on a matching done SHALL enter COMPLETE; a read SHALL latch i_rxData into o_rdata in that cycle.
REQ-034 COMPLETE SHALL pulse o_done for the captured requester for one cycle and return to IDLE; a new grant is possible in the following cycle.
REQ-035 The cycle counter SHALL clear on each begin pulse; reaching TIMEOUT_CYCLES in INIT_WAIT or WAIT SHALL set o_timeout and proceed as if done, with o_rdata=8'hFF for reads.
REQ-036 Begin pulses SHALL be at least one cycle after the preceding done, so the SPI master is always idle when started.
REQ-037 Address and data outputs SHALL be held stable from the begin pulse until the matching done pulse.

Reset
REQ-038 On i_resetn low: o_gnt=0, o_done=0, o_rdata=0, o_initIndex=0, o_initDone=0, o_timeout=0, o_txBegin=0, o_rxBegin=0, o_txAddress=0, o_txData=0, o_rxAddress=0, immediately and asynchronously.
REQ-039 Reset mid-transaction SHALL abandon it with no o_done pulse and restart the init sequence from index 0 after release.

Verification
REQ-040 NUM_INIT=3, table {(0x10,0xA1),(0x11,0xB2),(0x12,0xC3)}, i_txDone 40 cycles after each begin -> three writes in order, then o_initDone=1.
REQ-041 i_req=2'b11 held after init -> grants alternate 0,1,0,1; each o_done follows the matching o_gnt.
REQ-042 Requester 1 read of 0x2C with i_rxData=0x5E -> o_rxBegin with o_rxAddress=0x2C, o_done=2'b10, o_rdata=0x5E.
REQ-043 TIMEOUT_CYCLES=50 with no done returned -> o_timeout=1 at cycle 50, o_done pulses, o_rdata=0xFF, next grant proceeds.
REQ-044 Reset asserted during a WAIT -> all outputs zero; after release, init restarts at index 0 and no stale o_done is seen.
